// File: rtl/dm_responder.sv
// Data-memory responder for the M-stage load/store port: one request at a time,
// fixed wait states, word/half/byte access, and a one-cycle store log record.
module dm_responder #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_type,
  input  logic        req_sext,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        log_valid,
  output logic [31:0] log_pc,
  output logic [31:0] log_addr,
  output logic [31:0] log_data
);

  localparam int unsigned DEPTH     = 2 ** ADDR_W;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        we_q, we_d;
  logic [1:0]  type_q, type_d;
  logic        sext_q, sext_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] pc_q, pc_d;

  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        log_valid_q, log_valid_d;
  logic [31:0] log_pc_q, log_pc_d;
  logic [31:0] log_addr_q, log_addr_d;
  logic [31:0] log_data_q, log_data_d;

  logic [31:0] mem_q [DEPTH];

  logic              cur_we, cur_sext;
  logic [1:0]        cur_type;
  logic [31:0]       cur_addr, cur_wdata, cur_pc;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       cur_word, load_data, merged;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic              acc_err, commit, mem_we;

  // The access operands come straight from the request port when a
  // zero-wait accept commits on the same edge, otherwise from the latch.
  always_comb begin
    cur_we    = we_q;
    cur_type  = type_q;
    cur_sext  = sext_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_pc    = pc_q;
    if (state_q == S_IDLE) begin
      cur_we    = req_we;
      cur_type  = req_type;
      cur_sext  = req_sext;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_pc    = req_pc;
    end

    word_idx = cur_addr[ADDR_W+1:2];
    cur_word = mem_q[word_idx];

    acc_err = (cur_type == 2'd3) ||
              ((cur_type == 2'd0) && (cur_addr[1:0] != 2'b00)) ||
              ((cur_type == 2'd1) && cur_addr[0]);

    case (cur_addr[1:0])
      2'd0:    lane_byte = cur_word[7:0];
      2'd1:    lane_byte = cur_word[15:8];
      2'd2:    lane_byte = cur_word[23:16];
      default: lane_byte = cur_word[31:24];
    endcase
    lane_half = cur_addr[1] ? cur_word[31:16] : cur_word[15:0];

    case (cur_type)
      2'd0:    load_data = cur_word;
      2'd1:    load_data = {{16{cur_sext & lane_half[15]}}, lane_half};
      2'd2:    load_data = {{24{cur_sext & lane_byte[7]}}, lane_byte};
      default: load_data = '0;
    endcase

    merged = cur_word;
    case (cur_type)
      2'd0: merged = cur_wdata;
      2'd1: begin
        if (cur_addr[1]) merged[31:16] = cur_wdata[15:0];
        else             merged[15:0]  = cur_wdata[15:0];
      end
      2'd2: begin
        case (cur_addr[1:0])
          2'd0:    merged[7:0]   = cur_wdata[7:0];
          2'd1:    merged[15:8]  = cur_wdata[7:0];
          2'd2:    merged[23:16] = cur_wdata[7:0];
          default: merged[31:24] = cur_wdata[7:0];
        endcase
      end
      default: merged = cur_word;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    type_d      = type_q;
    sext_d      = sext_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    pc_d        = pc_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    log_valid_d = 1'b0;
    log_pc_d    = log_pc_q;
    log_addr_d  = log_addr_q;
    log_data_d  = log_data_q;
    commit      = 1'b0;
    mem_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          type_d  = req_type;
          sext_d  = req_sext;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          pc_d    = req_pc;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            cnt_d   = '0;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      rsp_err_d   = acc_err;
      rsp_rdata_d = '0;
      if (!acc_err) begin
        if (cur_we) begin
          mem_we      = 1'b1;
          log_valid_d = 1'b1;
          log_pc_d    = cur_pc;
          log_addr_d  = {cur_addr[31:2], 2'b00};
          log_data_d  = merged;
        end else begin
          rsp_rdata_d = load_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      type_q      <= '0;
      sext_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      pc_q        <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      log_valid_q <= 1'b0;
      log_pc_q    <= '0;
      log_addr_q  <= '0;
      log_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      type_q      <= type_d;
      sext_q      <= sext_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      pc_q        <= pc_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      log_valid_q <= log_valid_d;
      log_pc_q    <= log_pc_d;
      log_addr_q  <= log_addr_d;
      log_data_q  <= log_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[word_idx] <= merged;
    end
  end

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign req_ready = (state_q == S_IDLE) && reset;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign log_valid = log_valid_q;
  assign log_pc    = log_pc_q;
  assign log_addr  = log_addr_q;
  assign log_data  = log_data_q;

endmodule
